// File: rtl/sse_accumulator.sv
// Sum-of-squares accumulator: Q10.10 residuals squared into a 40-bit Q30.10 total.
// Define SSE_SATURATE_EN to clamp the total at all-ones on overflow instead of wrapping.
module sse_accumulator (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] n_samples,
    input  logic [19:0] ei,
    input  logic        ei_valid,
    output logic        ei_ready,
    output logic [39:0] sse,
    output logic        busy,
    output logic        done,
    output logic        ovf
);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [15:0]         r_count;
    logic [39:0]         r_sq;
    logic                r_sq_vld;
    logic [39:0]         r_sse;
    logic                r_ovf;

    logic                w_accept;
    logic                w_hs;
    logic signed [39:0]  w_ei_ext;
    logic [39:0]         w_prod;
    logic [39:0]         w_sq;
    logic [40:0]         w_sum;
    logic [39:0]         w_sse_next;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_hs     = (r_state == S_ACCUM) && ei_valid;

    // Square is never negative, so a logical shift drops the 10 extra fraction bits.
    assign w_ei_ext = {{20{ei[19]}}, ei};
    assign w_prod   = w_ei_ext * w_ei_ext;
    assign w_sq     = w_prod >> 10;
    assign w_sum    = {1'b0, r_sse} + {1'b0, r_sq};

`ifdef SSE_SATURATE_EN
    assign w_sse_next = w_sum[40] ? '1 : w_sum[39:0];
`else
    assign w_sse_next = w_sum[39:0];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = (n_samples == 16'd0) ? S_DONE : S_ACCUM;
            S_ACCUM: if (ei_valid && (r_count == 16'd1)) w_next = S_DRAIN;
            S_DRAIN: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count  <= '0;
            r_sq     <= '0;
            r_sq_vld <= 1'b0;
            r_sse    <= '0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_count  <= n_samples;
            r_sq     <= '0;
            r_sq_vld <= 1'b0;
            r_sse    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_sq_vld <= w_hs;
            if (w_hs) begin
                r_sq    <= w_sq;
                r_count <= r_count - 16'd1;
            end
            if (r_sq_vld) begin
                r_sse <= w_sse_next;
                if (w_sum[40]) r_ovf <= 1'b1;
            end
        end
    end

    always_comb begin
        ei_ready = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        unique case (r_state)
            S_IDLE:  busy     = 1'b0;
            S_ACCUM: ei_ready = 1'b1;
            S_DRAIN: ;
            S_DONE:  done     = 1'b1;
            default: busy     = 1'b0;
        endcase
    end

    assign sse = r_sse;
    assign ovf = r_ovf;

endmodule

// File: doc/sse_accumulator.md
SSE_ACCUMULATOR -- requirements
Module: sse_accumulator

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: reset  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-003 SHALL have port: start  input  1  one-cycle request to begin a new sum; sampled only in IDLE.
REQ-004 SHALL have port: n_samples  input  16  number of residuals to accumulate; captured on accepted start.
REQ-005 SHALL have port: ei  input  20  signed residual, Q10.10 two's complement.
REQ-006 SHALL have port: ei_valid  input  1  ei holds a valid residual.
REQ-007 SHALL have port: ei_ready  output  1  block accepts ei this cycle.
REQ-008 SHALL have port: sse  output  40  unsigned sum of squared residuals, Q30.10.
REQ-009 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port: done  output  1  one-cycle pulse when sse is final.
REQ-011 SHALL have port: ovf  output  1  sticky; set when any accumulation carries out of 40 bits.

Function
REQ-012 SHALL implement states IDLE, ACCUM, DRAIN, DONE.
REQ-013 IDLE: start=1 with n_samples>0 -> ACCUM; clear sse, ovf, square stage; load remaining count = n_samples.
REQ-014 IDLE: start=1 with n_samples=0 -> DONE directly; sse cleared to 0, ovf cleared.
REQ-015 start SHALL be ignored in ACCUM, DRAIN, DONE.
REQ-016 ei_ready SHALL be 1 only in ACCUM; handshake = ei_valid & ei_ready on a rising edge.
REQ-017 Each handshake SHALL register sq = (ei*ei)[39:10] (full signed 40-bit product, nonnegative, truncated by 10 bits, zero-extended to 40) plus a valid flag.
REQ-018 A registered sq SHALL be added to sse on the following edge (2-stage pipeline; accumulation rate 1 sample/cycle).
REQ-019 Handshake that decrements remaining count to 0 -> DRAIN; DRAIN lasts exactly one cycle, adding the final sq -> DONE.
REQ-020 DONE SHALL last one cycle with done=1, then -> IDLE; done=0 in all other states.
REQ-021 sse and ovf SHALL hold their values in IDLE until the next accepted start.
REQ-022 ei_valid=0 in ACCUM SHALL stall without changing count; no timeout.
REQ-023 Back-to-back: start asserted in the cycle after DONE SHALL be accepted.

Reset
REQ-024 reset=0 SHALL immediately force state IDLE, sse=0, ovf=0, done=0, ei_ready=0, busy=0, count=0, square stage cleared.
REQ-025 reset asserted mid-operation SHALL abandon the sum; no done pulse follows release.
REQ-026 First accepted start SHALL be on the first rising edge with reset=1.

Configuration
REQ-027 Macro SSE_SATURATE_EN defined: on carry-out sse SHALL clamp to 40'hFF_FFFF_FFFF and remain there for the rest of the sum; ovf set.
REQ-028 SSE_SATURATE_EN undefined: sse SHALL wrap modulo 2^40; ovf still set on carry-out.

Verification
REQ-029 reset low mid-ACCUM -> outputs all 0 within the same cycle, state IDLE, no done.
REQ-030 start, n=3, ei = 20'h00400, 20'hFF800, 20'h00200 (ei_valid continuous) -> done 2 cycles after last handshake, sse=40'h1500, ovf=0.
REQ-031 start, n=0 -> done the next cycle, sse=0, ei_ready never asserted.
REQ-032 n=2, ei_valid toggling 1,0,0,1 with ei=20'h80000 -> 2 handshakes only, sse=40'h2000_0000.
REQ-033 n=4097, ei=20'h80000 each -> SSE_SATURATE_EN: sse=40'hFF_FFFF_FFFF, ovf=1; undefined: sse=40'h00_1000_0000, ovf=1.
REQ-034 start held high during ACCUM and through DONE -> ignored until IDLE, new sum starts the cycle after DONE with sse cleared.
